// File: rtl/gray_counter.sv
// Up/down Gray-code counter with load and wrap flags.
// Binary count is the state; Gray output is derived from it.
module gray_counter #(
  parameter int WIDTH  = 3,
  parameter bit STICKY = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             ClrFlags,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] Binary,
  output logic             Overflow,
  output logic             Underflow
);

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] load_bin;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wrap_up, wrap_dn;

  // Gray-to-binary of the load value: prefix xor from the MSB down.
  always_comb begin
    load_bin = LoadVal;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      load_bin[i] = load_bin[i+1] ^ LoadVal[i];
    end
  end

  // Wrap detection only on real count steps; a load masks counting.
  always_comb begin
    wrap_up = En & Up & ~Load & (cnt_q == MAX);
    wrap_dn = En & ~Up & ~Load & (cnt_q == ZERO);
  end

  // Next count: load beats enable; otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (Load) begin
      cnt_d = load_bin;
    end else if (En) begin
      if (Up) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // Flag next state: sticky flags hold until cleared, set wins.
  always_comb begin
    ovf_d = wrap_up;
    unf_d = wrap_dn;
    if (STICKY) begin
      ovf_d = wrap_up | (ovf_q & ~ClrFlags);
      unf_d = wrap_dn | (unf_q & ~ClrFlags);
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign Output    = cnt_q ^ (cnt_q >> 1);
  assign Binary    = cnt_q;
  assign Overflow  = ovf_q;
  assign Underflow = unf_q;

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench for gray_counter: three instances
// (W3 sticky, W3 pulse, W5 sticky) on shared stimulus.
module tb_gray_counter;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       Reset = 1'b1, En = 1'b0, Up = 1'b0;
  logic       Load = 1'b0, ClrFlags = 1'b0;
  logic [4:0] lv5 = '0;
  logic [2:0] lv3;
  assign lv3 = lv5[2:0];

  logic [2:0] o3, b3, on, bn;
  logic [4:0] o5, b5;
  logic v3, u3, vn, un, v5, u5;

  gray_counter #(.WIDTH(3), .STICKY(1'b1)) u_s3 (
    .Clk(Clk), .Reset(Reset), .En(En), .Up(Up),
    .Load(Load), .LoadVal(lv3), .ClrFlags(ClrFlags),
    .Output(o3), .Binary(b3),
    .Overflow(v3), .Underflow(u3));

  gray_counter #(.WIDTH(3), .STICKY(1'b0)) u_p3 (
    .Clk(Clk), .Reset(Reset), .En(En), .Up(Up),
    .Load(Load), .LoadVal(lv3), .ClrFlags(ClrFlags),
    .Output(on), .Binary(bn),
    .Overflow(vn), .Underflow(un));

  gray_counter #(.WIDTH(5), .STICKY(1'b1)) u_s5 (
    .Clk(Clk), .Reset(Reset), .En(En), .Up(Up),
    .Load(Load), .LoadVal(lv5), .ClrFlags(ClrFlags),
    .Output(o5), .Binary(b5),
    .Overflow(v5), .Underflow(u5));

  typedef struct {
    int o3, b3, v3, u3;
    int on, bn, vn, un;
    int o5, b5, v5, u5;
    bit step;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  int m3 = 0, f3v = 0, f3u = 0;
  int mn = 0, fnv = 0, fnu = 0;
  int m5 = 0, f5v = 0, f5u = 0;

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int gray(input int b);
    return b ^ (b >> 1);
  endfunction

  // Inverse by search over the whole code space.
  function automatic int g2b(input int g, input int w);
    for (int b = 0; b < (1 << w); b++)
      if (gray(b) == g) return b;
    return -1;
  endfunction

  task automatic mdl(input int w, input bit st,
                     inout int b, inout int ov,
                     inout int uf);
    int  m;
    bit  wu, wd;
    int  lv;
    m  = 1 << w;
    lv = (w == 5) ? int'(lv5) : int'(lv3);
    wu = !Load && En && Up && b == m - 1;
    wd = !Load && En && !Up && b == 0;
    if (Reset) begin
      b = 0; ov = 0; uf = 0;
    end else begin
      if (Load) b = g2b(lv, w);
      else if (En) b = Up ? (b + 1) % m : (b + m - 1) % m;
      if (st) begin
        ov = wu ? 1 : (ClrFlags ? 0 : ov);
        uf = wd ? 1 : (ClrFlags ? 0 : uf);
      end else begin
        ov = int'(wu);
        uf = int'(wd);
      end
    end
  endtask

  task automatic cyc(input bit r, input bit e, input bit u,
                     input bit l, input logic [4:0] v,
                     input bit c);
    exp_t x;
    Reset = r; En = e; Up = u;
    Load = l; lv5 = v; ClrFlags = c;
    @(posedge Clk);
    mdl(3, 1'b1, m3, f3v, f3u);
    mdl(3, 1'b0, mn, fnv, fnu);
    mdl(5, 1'b1, m5, f5v, f5u);
    x.o3 = gray(m3); x.b3 = m3; x.v3 = f3v; x.u3 = f3u;
    x.on = gray(mn); x.bn = mn; x.vn = fnv; x.un = fnu;
    x.o5 = gray(m5); x.b5 = m5; x.v5 = f5v; x.u5 = f5u;
    x.step = !r && !l && e;
    q.push_back(x);
    #1;
  endtask

  // Monitor: pop one expectation per cycle and compare.
  logic [2:0] prev3;
  always @(negedge Clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("s3_out", 16'(o3), 16'(e.o3));
      chk("s3_bin", 16'(b3), 16'(e.b3));
      chk("s3_ovf", 16'(v3), 16'(e.v3));
      chk("s3_unf", 16'(u3), 16'(e.u3));
      chk("p3_out", 16'(on), 16'(e.on));
      chk("p3_bin", 16'(bn), 16'(e.bn));
      chk("p3_ovf", 16'(vn), 16'(e.vn));
      chk("p3_unf", 16'(un), 16'(e.un));
      chk("s5_out", 16'(o5), 16'(e.o5));
      chk("s5_bin", 16'(b5), 16'(e.b5));
      chk("s5_ovf", 16'(v5), 16'(e.v5));
      chk("s5_unf", 16'(u5), 16'(e.u5));
      if (e.step)
        chk("s3_onebit", 16'($countones(prev3 ^ o3)), 16'd1);
      prev3 = o3;
    end
  end

  initial begin : stim
    int seq[8];
    int seen[32];
    int uniq;
    seq = '{1, 3, 2, 6, 7, 5, 4, 0};

    cyc(1, 1, 1, 1, 5'h1f, 1);
    chk("rst_out", 16'(o3), 16'd0);
    chk("rst_flags", 16'({v3, u3, vn, un}), 16'd0);

    // Up sequence and overflow on the 8th edge.
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 1, 0, 0, 0);
      chk("up_seq", 16'(o3), 16'(seq[i]));
    end
    chk("up_wrap_ovf", 16'(v3), 16'd1);

    // Sticky hold, clear, then set-wins-over-clear.
    repeat (3) cyc(0, 0, $urandom_range(1), 0, 0, 0);
    chk("sticky_hold", 16'(v3), 16'd1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("clr_ovf", 16'(v3), 16'd0);
    repeat (7) cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 1);
    chk("set_wins", 16'(v3), 16'd1);

    // Down wrap then immediate direction change.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("dn_out", 16'(o3), 16'b100);
    chk("dn_bin", 16'(b3), 16'b111);
    chk("dn_unf", 16'(u3), 16'd1);
    cyc(0, 1, 1, 0, 0, 0);
    chk("dir_out", 16'(o3), 16'd0);
    chk("dir_flags", 16'({v3, u3}), 16'b11);

    // Load beats enable.
    cyc(0, 1, 0, 1, 5'b00110, 0);
    chk("ld_out", 16'(o3), 16'b110);
    chk("ld_bin", 16'(b3), 16'b100);
    cyc(0, 1, 1, 0, 0, 0);
    chk("ld_next", 16'(o3), 16'b111);

    // Pulse flags; reset mid-count with En high.
    cyc(0, 0, 0, 1, 5'b00100, 0);
    cyc(0, 1, 1, 0, 0, 0);
    chk("pulse_hi", 16'(vn), 16'd1);
    cyc(0, 0, 1, 0, 0, 0);
    chk("pulse_lo", 16'(vn), 16'd0);
    cyc(0, 0, 0, 1, 5'b00011, 0);
    cyc(1, 1, 1, 0, 0, 0);
    chk("rst_mid", 16'({on, vn, un}), 16'd0);

    // Five-bit full cycle: all codes distinct.
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) seen[i] = 0;
    for (int i = 0; i < 32; i++) begin
      cyc(0, 1, 1, 0, 0, 0);
      seen[o5]++;
    end
    uniq = 0;
    for (int i = 0; i < 32; i++) if (seen[i] == 1) uniq++;
    chk("w5_distinct", 16'(uniq), 16'd32);
    chk("w5_ovf", 16'(v5), 16'd1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(39) == 0,
          $urandom_range(3) != 0,
          $urandom_range(1),
          $urandom_range(7) == 0,
          5'($urandom),
          $urandom_range(5) == 0);
    end

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge Clk);
    @(negedge Clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 Parameter WIDTH, default 3, counter width in bits; legal range 2..16.
REQ-002 Parameter STICKY, default 1; 1 = wrap flags hold until cleared, 0 = wrap flags pulse for one cycle.
REQ-003 Clk  input  1  clock; all state updates on the rising edge.
REQ-004 Reset  input  1  reset; synchronous, active-high.
REQ-005 En  input  1  count enable.
REQ-006 Up  input  1  direction; 1 = up, 0 = down; sampled only when En=1.
REQ-007 Load  input  1  synchronous load of LoadVal.
REQ-008 LoadVal  input  WIDTH  load value, Gray-coded.
REQ-009 ClrFlags  input  1  clears Overflow and Underflow (STICKY=1 only).
REQ-010 Output  output  WIDTH  current count, Gray-coded, registered.
REQ-011 Binary  output  WIDTH  current count, binary equivalent of Output.
REQ-012 Overflow  output  1  up-count wrap indicator.
REQ-013 Underflow  output  1  down-count wrap indicator.

Function
REQ-014 State SHALL be a WIDTH-bit binary count B; Output SHALL equal B xor (B >> 1); Binary SHALL equal B; both combinationally derived from registered B, no extra latency.
REQ-015 Update priority per edge SHALL be Reset > Load > En; with none active, B, Overflow and Underflow hold (STICKY=1).
REQ-016 Load=1: B SHALL take the Gray-to-binary conversion of LoadVal (bit i = xor of LoadVal[WIDTH-1:i]); En and Up are ignored that cycle; flags are unaffected by Load except via REQ-021/REQ-022.
REQ-017 En=1, Up=1: B SHALL become B+1 modulo 2^WIDTH; Output therefore steps one Gray code (single-bit change).
REQ-018 En=1, Up=0: B SHALL become B-1 modulo 2^WIDTH.
REQ-019 Up-wrap: En=1, Up=1, B = 2^WIDTH-1 (Output = 1 followed by WIDTH-1 zeros) -> B=0 and Overflow SHALL be 1 from the next cycle.
REQ-020 Down-wrap: En=1, Up=0, B=0 -> B = 2^WIDTH-1 and Underflow SHALL be 1 from the next cycle.
REQ-021 STICKY=1: flags SHALL remain 1 until ClrFlags=1 or Reset; a wrap in the same cycle as ClrFlags=1 SHALL leave the corresponding flag set (set wins); ClrFlags clears the other flag.
REQ-022 STICKY=0: each flag SHALL be 1 exactly in the cycle following its wrap edge and 0 otherwise; ClrFlags has no effect.
REQ-023 Overflow and Underflow SHALL both be 1 only if STICKY=1 and both wraps occurred without an intervening clear.
REQ-024 Direction change between consecutive enabled cycles SHALL take effect immediately with no dead cycle.
REQ-025 En=0 with Load=0 SHALL hold B regardless of Up.

Reset
REQ-026 Reset=1 at a rising edge SHALL set B=0 (Output=0, Binary=0), Overflow=0, Underflow=0, overriding Load, En and ClrFlags.
REQ-027 Reset asserted mid-count or while a flag is set SHALL clear all state within that edge; counting resumes from 0 on the first edge after Reset deasserts.
REQ-028 No output SHALL be X after the first reset edge.

Verification (WIDTH=3 unless noted)
REQ-029 Reset, then En=1, Up=1 for 8 edges -> Output sequence 001,011,010,110,111,101,100,000; Overflow=1 after the 8th edge; exactly one Output bit changes per step.
REQ-030 STICKY=1: after REQ-029, En=0 for 3 cycles -> Overflow stays 1; ClrFlags=1 one cycle -> Overflow=0; repeat with a wrap in the same cycle as ClrFlags -> Overflow stays 1.
REQ-031 From reset, En=1, Up=0 one edge -> Output=100, Binary=111, Underflow=1; then Up=1 one edge -> Output=000, Overflow set, Underflow still 1 (STICKY=1).
REQ-032 Load=1, LoadVal=110, En=1, Up=0 simultaneously -> Output=110, Binary=100 (load wins); next edge with Up=1 -> Output=111.
REQ-033 STICKY=0: up-wrap from 100 -> Overflow high exactly one cycle; Reset asserted at count 011 with En=1 -> Output=000, flags 0 next cycle.
REQ-034 WIDTH=5: Up-count 32 edges from 0 -> all 32 Gray codes distinct, Binary matches Gray-to-binary of Output every cycle, Overflow on wrap 10000 -> 00000.
